// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Multiply is shift-add retiring MUL_STEP multiplier bits per cycle; divide is
// restoring, one quotient bit per cycle. Signed ops run on magnitudes and get
// their signs restored in a single FIX cycle before HI/LO are written.
//
// state | meaning
// IDLE  | accepts MTHI/MTLO (same edge) or latches a mult/div
// CALC  | iterating; counter counts down to 0
// FIX   | sign correction; HI/LO written and done_o raised on exit
module hilo_muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_N = CW'(WIDTH / MUL_STEP);
  localparam logic [CW-1:0] DIV_N = CW'(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic                 is_div, neg_q, neg_r, dz;

  logic                 take_start, accept_md, mt_hi, mt_lo, write_res;
  logic                 op_signed, op_div, a_sgn, b_sgn;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   mul_acc_nxt, div_acc_nxt;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     q_fix, r_fix;
  logic [2*WIDTH-1:0]   res;

  // A squash in the same cycle drops the start; once busy, starts are ignored.
  assign take_start = (state == IDLE) && start_i && !flush_i;
  assign accept_md  = take_start && (op_i >= OP_MULT) && (op_i <= OP_DIVU);
  assign mt_hi      = take_start && (op_i == OP_MTHI);
  assign mt_lo      = take_start && (op_i == OP_MTLO);
  assign write_res  = (state == FIX) && !flush_i;
  assign busy_o     = (state != IDLE);

  // Operand magnitudes and result signs for the op being accepted.
  always_comb begin
    op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    op_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
    a_sgn     = op_signed && a_i[WIDTH-1];
    b_sgn     = op_signed && b_i[WIDTH-1];
    a_mag     = a_sgn ? -a_i : a_i;
    b_mag     = b_sgn ? -b_i : b_i;
  end

  // One multiply iteration: MUL_STEP shift-add steps, multiplier in acc low half.
  always_comb begin
    mul_acc_nxt = acc;
    mul_sum     = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      mul_sum     = {1'b0, mul_acc_nxt[2*WIDTH-1:WIDTH]} +
                    (mul_acc_nxt[0] ? {1'b0, opnd} : '0);
      mul_acc_nxt = {mul_sum, mul_acc_nxt[WIDTH-1:1]};
    end
  end

  // One restoring-divide iteration: acc holds {remainder, dividend/quotient}.
  always_comb begin
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
    if (!div_trial[WIDTH])
      div_acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
  end

  // Sign correction applied during FIX; divide-by-zero forces an all-ones quotient.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    q_fix    = dz ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    res      = is_div ? {r_fix, q_fix} : prod_fix;
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_md) state_nxt = CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath, counter and the architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (accept_md) begin
        is_div <= op_div;
        neg_q  <= a_sgn ^ b_sgn;
        neg_r  <= a_sgn;
        dz     <= op_div && (b_i == '0);
        cnt    <= op_div ? DIV_N : MUL_N;
        if (op_div) begin
          acc  <= {{WIDTH{1'b0}}, a_mag};
          opnd <= b_mag;
        end else begin
          acc  <= {{WIDTH{1'b0}}, b_mag};
          opnd <= a_mag;
        end
      end else if (state == CALC) begin
        acc <= is_div ? div_acc_nxt : mul_acc_nxt;
        cnt <= flush_i ? '0 : cnt - CW'(1);
      end
      if (mt_hi) hi_o <= a_i;
      if (mt_lo) lo_o <= a_i;
      if (write_res) begin
        hi_o   <= res[2*WIDTH-1:WIDTH];
        lo_o   <= res[WIDTH-1:0];
        done_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: a 32-bit MUL_STEP=1 instance and a
// MUL_STEP=4 instance. Expected HI/LO pairs are queued when an op is issued
// and popped when done_o is seen.
module tb_hilo_muldiv_unit;

  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                         DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

  logic        clk = 1'b0;
  logic        rst, start_i, start4, flush_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, done_o, busy4, done4;
  logic [31:0] hi_o, lo_o, hi4, lo4;

  int tests = 0;
  int fails = 0;
  logic [63:0] sbq[$];

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  hilo_muldiv_unit #(.WIDTH(32), .MUL_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .busy_o(busy4), .done_o(done4), .hi_o(hi4), .lo_o(lo4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference results taken from the architectural definition of each op.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sq, sr;
    case (op)
      MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      MULTU: return {32'b0, a} * {32'b0, b};
      DIV: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {sr, sq};
      end
      DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    tick();
    start_i = 1'b0; op_i = NOP;
  endtask

  // Called just after the accepting edge; checks latency, stall length, HI/LO
  // stability, then pops and compares the queued result.
  task automatic wait_done(input string tag, input int lat);
    int cyc, busy_n;
    logic moved;
    logic [63:0] hold, exp;
    cyc = 0; busy_n = 0; moved = 1'b0; hold = {hi_o, lo_o};
    while (done_o !== 1'b1 && cyc < 200) begin
      if (busy_o === 1'b1) busy_n++;
      if ({hi_o, lo_o} !== hold) moved = 1'b1;
      tick();
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    chk({tag, " busy cycles"}, 64'(busy_n), 64'(lat));
    chk({tag, " hilo stable"}, {63'd0, moved}, 64'd0);
    exp = (sbq.size() > 0) ? sbq.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    chk({tag, " result"}, {hi_o, lo_o}, exp);
    chk({tag, " busy at done"}, {63'd0, busy_o}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    sbq.push_back(exp);
    issue(op, a, b);
    wait_done(tag, 33);
    tick();
    chk({tag, " done pulse"}, {63'd0, done_o}, 64'd0);
  endtask

  task automatic no_done(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done_o === 1'b1) n++;
      tick();
    end
    chk({tag, " no done"}, 64'(n), 64'd0);
  endtask

  initial begin
    logic [63:0] hold;
    int cyc;
    rst = 1'b1; start_i = 1'b0; start4 = 1'b0; flush_i = 1'b0;
    op_i = NOP; a_i = '0; b_i = '0;

    tick(); tick();
    chk("reset hi", {32'd0, hi_o}, 64'd0);
    chk("reset lo", {32'd0, lo_o}, 64'd0);
    chk("reset busy", {63'd0, busy_o}, 64'd0);
    chk("reset done", {63'd0, done_o}, 64'd0);
    rst = 1'b0;
    tick();

    issue(MTHI, 32'h12345678, 32'd0);
    chk("mthi hi", {32'd0, hi_o}, 64'h12345678);
    chk("mthi busy", {63'd0, busy_o}, 64'd0);
    issue(MTLO, 32'h9ABCDEF0, 32'd0);
    chk("mtlo lo", {32'd0, lo_o}, 64'h9ABCDEF0);
    chk("mtlo hi kept", {32'd0, hi_o}, 64'h12345678);
    chk("mtlo busy", {63'd0, busy_o}, 64'd0);
    chk("mtlo done", {63'd0, done_o}, 64'd0);

    run_op("multu", MULTU, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE);
    run_op("mult", MULT, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE);
    run_op("div 7/-2", DIV, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    run_op("div min/-1", DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_op("divu by 0", DIVU, 32'd100, 32'd0, 64'h00000064_FFFFFFFF);
    run_op("div neg by 0", DIV, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF);
    run_op("div -7/2", DIV, 32'hFFFFFFF9, 32'd2, model(DIV, 32'hFFFFFFF9, 32'd2));
    run_op("divu big", DIVU, 32'hFEDCBA98, 32'h00012345, model(DIVU, 32'hFEDCBA98, 32'h00012345));
    run_op("mult mixed", MULT, 32'h12345678, 32'hFEDCBA98, model(MULT, 32'h12345678, 32'hFEDCBA98));
    run_op("multu big", MULTU, 32'hDEADBEEF, 32'hCAFEBABE, model(MULTU, 32'hDEADBEEF, 32'hCAFEBABE));

    // Flush mid-CALC, with an MTHI attempted while busy.
    hold = {hi_o, lo_o};
    issue(MULT, 32'h00000003, 32'h00000005);
    tick(); tick();
    start_i = 1'b1; op_i = MTHI; a_i = 32'hAAAA5555;
    tick();
    start_i = 1'b0; op_i = NOP;
    chk("mthi while busy", {hi_o, lo_o}, hold);
    repeat (7) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush calc busy", {63'd0, busy_o}, 64'd0);
    chk("flush calc hilo", {hi_o, lo_o}, hold);
    no_done("flush calc", 40);
    chk("flush calc hilo later", {hi_o, lo_o}, hold);

    // Flush in the FIX cycle.
    issue(MULTU, 32'h00000007, 32'h00000009);
    repeat (32) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush fix busy", {63'd0, busy_o}, 64'd0);
    chk("flush fix done", {63'd0, done_o}, 64'd0);
    chk("flush fix hilo", {hi_o, lo_o}, hold);
    no_done("flush fix", 5);

    // Back-to-back: second op issued in the done_o cycle.
    sbq.push_back(model(MULTU, 32'h0000FFFF, 32'h00010001));
    issue(MULTU, 32'h0000FFFF, 32'h00010001);
    wait_done("b2b first", 33);
    sbq.push_back(model(MULTU, 32'h89ABCDEF, 32'h00000100));
    issue(MULTU, 32'h89ABCDEF, 32'h00000100);
    wait_done("b2b second", 33);
    tick();

    // Reset mid-op.
    issue(MULT, 32'h11111111, 32'h22222222);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst hi", {32'd0, hi_o}, 64'd0);
    chk("mid rst lo", {32'd0, lo_o}, 64'd0);
    chk("mid rst busy", {63'd0, busy_o}, 64'd0);
    chk("mid rst done", {63'd0, done_o}, 64'd0);
    no_done("mid rst", 40);

    // MUL_STEP=4 instance.
    sbq.push_back(64'h0000000D_EADBEEF0);
    start4 = 1'b1; op_i = MULTU; a_i = 32'hDEADBEEF; b_i = 32'h00000010;
    tick();
    start4 = 1'b0; op_i = NOP;
    chk("step4 busy", {63'd0, busy4}, 64'd1);
    cyc = 0;
    while (done4 !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("step4 latency", 64'(cyc), 64'd9);
    chk("step4 result", {hi4, lo4}, (sbq.size() > 0) ? sbq.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD);
    tick();

    sbq.push_back(model(MULT, 32'hFFFFFFFD, 32'h00000005));
    start4 = 1'b1; op_i = MULT; a_i = 32'hFFFFFFFD; b_i = 32'h00000005;
    tick();
    start4 = 1'b0; op_i = NOP;
    cyc = 0;
    while (done4 !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("step4 mult latency", 64'(cyc), 64'd9);
    chk("step4 mult result", {hi4, lo4}, (sbq.size() > 0) ? sbq.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU in the execute stage. It is driven by the decoded mdu op and the forwarded operands.
- busy_o stalls the pipeline, so MFHI/MFLO read hi_o/lo_o only when the unit is idle.

Parameters:
- WIDTH, 32, operand and HI/LO width. Must be even and ≥ 8.
- MUL_STEP, 1, multiplier bits retired per cycle. Legal values are 1, 2, 4, and it must divide WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start_i  in  1  op_i/a_i/b_i valid this cycle
- op_i  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (ignored)
- a_i  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source
- b_i  in  WIDTH  rt operand: multiplier or divisor
- flush_i  in  1  cancel in-flight op (exception/branch squash)
- busy_o  out  1  unit in CALC or FIX; pipeline stall request
- done_o  out  1  one-cycle pulse when HI/LO take a mult/div result
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- rst: state IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, counter=0.
  - Any op in flight is abandoned with no HI/LO write.
  - rst has priority over everything.
- FSM states are IDLE, CALC and FIX. busy_o is 1 exactly when state≠IDLE. All outputs are registered.
- IDLE, start_i=1:
  - MTHI: hi_o←a_i at that edge. MTLO: lo_o←a_i. State stays IDLE, busy_o stays 0, done_o stays 0.
  - MULT/MULTU/DIV/DIVU:
    - Latch operand magnitudes; signed ops take the absolute value and record the result signs.
    - Load counter N, where N=WIDTH/MUL_STEP for multiply and N=WIDTH for divide.
    - Go to CALC.
  - NOP/reserved: no effect.
- CALC:
  - Multiply: shift-add, MUL_STEP bits per cycle, into a 2·WIDTH accumulator.
  - Divide: restoring divide, one quotient bit per cycle.
  - Counter decrements each cycle; counter reaching 0 moves to FIX. CALC therefore lasts N cycles.
- FIX (one cycle): apply sign correction. At the exiting edge write HI/LO, set done_o=1 for one cycle, and return to IDLE.
- Latency: with the accepting edge as edge 0, the new HI/LO and done_o=1 appear after edge N+1.
  - WIDTH=32, MUL_STEP=1: edge 33 for mult and div.
  - MUL_STEP=4: edge 9 for mult.
- Results:
  - MULT/MULTU: {hi,lo} = full 2·WIDTH product (signed or unsigned).
  - DIV/DIVU: lo=quotient (truncated toward zero), hi=remainder. The remainder takes the sign of the dividend.
- Boundary cases:
  - Divide by zero (DIV or DIVU): lo=all ones, hi=a_i. Still takes the full N+1 cycles.
  - DIV with a_i=most-negative and b_i=−1: lo=most-negative, hi=0.
  - start_i while busy_o=1: ignored entirely, including MTHI/MTLO. Decode must hold off via stall.
  - start_i in the cycle done_o=1: accepted, since the unit is in IDLE. Back-to-back ops are allowed.
  - flush_i=1: state→IDLE next edge; no HI/LO write; done_o=0.
    - Takes priority over start_i in the same cycle; that start is dropped.
    - Flush in the FIX cycle also suppresses the write.
    - Flush while IDLE has no effect.
- hi_o/lo_o are stable while busy_o=1 and hold their old values until the FIX edge.

Test Plan:
- Reset check: rst=1 for 2 cycles → hi_o=0, lo_o=0, busy_o=0, done_o=0. Then MTHI a=0x12345678 and MTLO a=0x9ABCDEF0 → hi/lo take those values one edge each, busy_o never rises.
- Multiply: MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE. MULT with the same operands → hi=0xFFFFFFFF, lo=0xFFFFFFFE. Both after edge 33; busy_o=1 for exactly 33 cycles; done_o pulses once.
- Signed divide: DIV a=7, b=−2 → lo=0xFFFFFFFD, hi=0x00000001. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=100.
- Flush and ignored start: MULT at edge 0, flush_i at edge 10 → busy_o=0 after edge 11, HI/LO unchanged, no done_o. Repeat with flush in the FIX cycle → same result. MTHI issued while busy → ignored.
- Back-to-back and reset mid-op: MULTU issued the same cycle done_o=1 → accepted, second result after a further 33 edges. rst at CALC cycle 5 → all outputs return to reset values.
- MUL_STEP=4 build: MULTU 0xDEADBEEF×0x10 → hi=0x0000000D, lo=0xEADBEEF0 after edge 9.
